// File: rtl/dmem_pkg.sv
// Shared defaults and FSM state encoding for the data-memory controller.
package dmem_pkg;

  localparam int unsigned DefAddrW = 8;
  localparam int unsigned DefDataW = 16;
  localparam int unsigned DefLat   = 2;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StFin
  } state_e;

endpackage

// File: rtl/dmem_ctrl_if.sv
// Register-bus side of dmem_ctrl: request, address/data and status signals.
interface dmem_ctrl_if
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW
) ();

  logic [ADDR_W-1:0] ADDR;
  logic [DATA_W-1:0] DIN;
  logic              RD;
  logic              WR;
  logic [DATA_W-1:0] DOUT;
  logic              BUSY;
  logic              DONE;
  logic              PERR;

  modport master (
    output ADDR, DIN, RD, WR,
    input  DOUT, BUSY, DONE, PERR
  );

  modport slave (
    input  ADDR, DIN, RD, WR,
    output DOUT, BUSY, DONE, PERR
  );

endinterface

// File: rtl/dmem_array.sv
// Single-port storage with synchronous write and registered read.
// With DMEM_CTRL_PARITY_EN each word carries an even-parity bit checked on read.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              en,
  input  logic              we,
  input  logic              clr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rerr
);

  localparam int unsigned Depth = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [Depth];
  logic [DATA_W-1:0] rdata_q;

  // Contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem_q[addr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      rdata_q <= '0;
    end else if (en && !we) begin
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

`ifdef DMEM_CTRL_PARITY_EN
  logic par_q [Depth];
  logic rerr_q;

  always_ff @(posedge clk) begin
    if (en && we) begin
      par_q[addr] <= ^wdata;
    end
  end

  // Error flag is sticky until the next accepted request.
  always_ff @(posedge clk) begin
    if (RST || clr) begin
      rerr_q <= 1'b0;
    end else if (en && !we) begin
      rerr_q <= (^mem_q[addr]) ^ par_q[addr];
    end
  end

  assign rerr = rerr_q;
`else
  logic unused_clr;
  assign unused_clr = clr;
  assign rerr       = 1'b0;
`endif

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory access controller: IDLE -> ACCESS (LAT cycles) -> FIN (DONE pulse).
// Optional parity storage/checking enabled by DMEM_CTRL_PARITY_EN.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned LAT    = DefLat
) (
  input logic        clk,
  input logic        RST,
  dmem_ctrl_if.slave bus
);

  localparam logic [3:0] LatCnt = 4'(LAT);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              op_wr_q, op_wr_d;
  logic              accept;
  logic              finish;
  logic              arr_en;
  logic [DATA_W-1:0] arr_rdata;
  logic              arr_rerr;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    op_wr_d = op_wr_q;
    accept  = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.RD || bus.WR) begin
          accept  = 1'b1;
          addr_d  = bus.ADDR;
          wdata_d = bus.DIN;
          // Read wins when both are requested together.
          op_wr_d = !bus.RD;
          cnt_d   = LatCnt;
          state_d = StAccess;
        end
      end
      StAccess: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          finish  = 1'b1;
          state_d = StFin;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      op_wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      op_wr_q <= op_wr_d;
    end
  end

  // Reset on the completing edge aborts the array update too.
  assign arr_en = finish && !RST;

  dmem_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_array (
    .clk  (clk),
    .RST  (RST),
    .en   (arr_en),
    .we   (op_wr_q),
    .clr  (accept),
    .addr (addr_q),
    .wdata(wdata_q),
    .rdata(arr_rdata),
    .rerr (arr_rerr)
  );

  assign bus.DOUT = arr_rdata;
  assign bus.BUSY = (state_q != StIdle);
  assign bus.DONE = (state_q == StFin);
  assign bus.PERR = arr_rerr;

endmodule
